// File: rtl/dff_response_checker.sv
// dff_response_checker: judges a single-bit D flip-flop DUT by predicting q
// from d delayed LAT cycles and counting checked / mismatching cycles.
// Optional build macro QNOT_CHECK_EN also flags cycles where qnot != ~q.
module dff_response_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic             q,
    input  logic             qnot,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             fail,
    output logic             pass
);

    localparam int unsigned FILL_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_CHECK = 2'b10
    } state_t;

    state_t            st_q, st_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [LAT-1:0]    dly_q;
    logic              exp_bit;
    logic              do_chk;
    logic              mism;
    logic [CNT_W-1:0]  chk_d, err_d, first_d;
    logic              fail_d, pass_d;

    assign state   = st_q;
    assign exp_bit = dly_q[LAT-1];
    assign do_chk  = (st_q == S_CHECK) && en;

`ifdef QNOT_CHECK_EN
    // q must follow delayed d and qnot must be the complement of q
    assign mism = (q != exp_bit) || (qnot == q);
`else
    logic unused_qnot;
    assign unused_qnot = qnot;
    // only q is judged against the delayed stimulus
    assign mism = (q != exp_bit);
`endif

    // Delay line of d, shifted every cycle independent of FSM state
    always_ff @(posedge clk) begin
        if (rst) dly_q <= '0;
        else     dly_q <= LAT'({dly_q, d});
    end

    // FSM and fill counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= S_IDLE;
            fill_q <= '0;
        end else begin
            st_q   <= st_d;
            fill_q <= fill_d;
        end
    end

    // Next state: FILL waits LAT cycles for the delay line to hold valid d
    always_comb begin
        st_d   = st_q;
        fill_d = fill_q;
        case (st_q)
            S_IDLE: begin
                if (en) begin
                    st_d   = S_FILL;
                    fill_d = '0;
                end
            end
            S_FILL: begin
                if (!en)                                st_d = S_IDLE;
                else if (fill_q == FILL_W'(LAT - 1))   st_d = S_CHECK;
                else                                    fill_d = fill_q + FILL_W'(1);
            end
            S_CHECK: begin
                if (!en) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Next counter values with saturation; at most one error per cycle
    always_comb begin
        chk_d   = chk_cnt;
        err_d   = err_cnt;
        first_d = first_err;
        fail_d  = fail;
        if (do_chk) begin
            if (chk_cnt != CNT_MAX) chk_d = chk_cnt + CNT_W'(1);
            if (mism) begin
                fail_d = 1'b1;
                if (err_cnt != CNT_MAX) err_d = err_cnt + CNT_W'(1);
                if (!fail) first_d = chk_cnt;
            end
        end
        pass_d = (chk_d != '0) && (err_d == '0);
    end

    // Result registers; cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            fail      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            chk_cnt   <= chk_d;
            err_cnt   <= err_d;
            first_err <= first_d;
            fail      <= fail_d;
            pass      <= pass_d;
        end
    end

endmodule
